snn_image_loader: RTL and testbench
===================================

// Module: snn_image_loader
// PURPOSE
//  Front-end writer for the SNN inference path. Accepts an image over a byte
//  ready/valid stream (UART RX side) and unpacks it into 784 one-bit pixels.
//  Writes the pixels into the input-unit RAM write port, then pulses core_start.
//  Waits for core_done, latches core_digit and returns it as an ASCII byte on a
//  ready/valid TX stream.
// PARAMETERS
//  NUM_PIXELS  784    pixels per image (input-unit RAM depth used)
//  ADDR_W      10     input-unit RAM address width
//  THRESH      8'h80  grayscale threshold; used only with SNN_LOADER_THRESH_EN
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  rx_data      in   8       image byte
//  rx_valid     in   1       rx_data valid
//  rx_ready     out  1       loader accepts rx_data this cycle
//  ram_wr_addr  out  ADDR_W  input-unit RAM write address
//  ram_wr_data  out  1       pixel bit to write
//  ram_we       out  1       input-unit RAM write enable
//  core_start   out  1       one-cycle start pulse to SNN core
//  core_done    in   1       SNN core finished (single-cycle pulse)
//  core_digit   in   4       classified digit, valid with core_done
//  tx_data      out  8       ASCII result byte
//  tx_valid     out  1       tx_data valid
//  tx_ready     in   1       TX sink accepts tx_data
//  busy         out  1       high in every state except LOAD
// BEHAVIOUR
//  - Reset: state=IDLE, ram_wr_addr=0, all outputs 0 incl. rx_ready, tx_data=0.
//  - FSM IDLE->LOAD unconditionally; 1st cycle after reset release is IDLE.
//  - LOAD: rx_ready=1. On rx_valid&rx_ready, capture byte to shift reg, bitcnt=0.
//    Then go to UNPACK.
//  - UNPACK: rx_ready=0, ram_we=1, ram_wr_data=shreg[0] (LSB = lowest address).
//    Each edge: shift right, ram_wr_addr++, bitcnt++.
//    After 8th write: if pixel NUM_PIXELS-1 was written -> START, else -> LOAD.
//  - Packed image = NUM_PIXELS/8 = 98 bytes; no per-byte stall beyond 8 cycles.
//  - START: core_start=1 for exactly one cycle; ram_wr_addr cleared to 0.
//    Then go to WAIT_DONE.
//  - WAIT_DONE: on core_done, latch digit -> TX.
//    tx_data = 8'h30+digit if digit<=9, else 8'h3F ('?').
//  - TX: tx_valid=1; tx_data held stable until tx_valid&tx_ready, then LOAD.
//    tx_valid drops the cycle after the handshake.
//  - Ignored conditions:
//    core_done outside WAIT_DONE; rx_valid while rx_ready=0 (byte not consumed);
//    tx_ready while tx_valid=0.
//  - Simultaneous events:
//    rx_valid present at a TX handshake is accepted no earlier than next cycle.
//    core_done in the cycle START is exited is not seen (WAIT_DONE not entered).
//  - ram_wr_addr never exceeds NUM_PIXELS-1; wrap to 0 occurs only via START/reset.
//  - Reset mid-operation: partial image discarded; reload restarts at address 0.
//  - Latency: last rx byte handshake -> core_start high 9 cycles later.
//    core_done -> tx_valid high next cycle.
// CONFIGURATION
//  SNN_LOADER_THRESH_EN defined:
//    - Each rx byte is one grayscale pixel; NUM_PIXELS=784 bytes per image.
//    - UNPACK is one write cycle: ram_wr_data = (rx_byte >= THRESH).
//  Not defined (default):
//    - Packed mode, 8 pixels per byte LSB-first, as above.
// TESTING
//  98 x 8'hAA, rx_valid held -> 784 writes, data 0,1,0,1..., addr 0..783.
//    rx_ready low during every UNPACK; single core_start, 9 cycles after last byte.
//  WAIT_DONE, core_done with digit 7, tx_ready low 5 cycles -> tx_data 8'h37.
//    tx_valid held 5 cycles, drops after handshake; rx_ready=1 next.
//  core_done with digit 4'hC -> tx_data 8'h3F.
//  core_done pulsed during LOAD -> no tx_valid, state stays LOAD, addr unchanged.
//  rst_n low after 40 bytes, then full 98-byte frame -> addr restarts at 0.
//    784 correct writes, exactly one core_start.
//  THRESH_EN: bytes 8'h7F, 8'h80, 8'hFF repeating, 784 bytes -> data 0,1,1...
//    One write per byte; core_start after byte 784.

Source files
------------

// File: rtl/snn_image_loader.sv
// snn_image_loader: front-end writer for the SNN inference path.
// Receives an image over a byte ready/valid stream, writes it bit by bit into
// the input-unit RAM, starts the core, waits for its result and returns the
// classified digit as an ASCII character on a ready/valid TX stream.
// Build option: SNN_LOADER_THRESH_EN selects grayscale mode (one byte per
// pixel, thresholded against THRESH). Default is packed mode (8 pixels per
// byte, LSB first).
module snn_image_loader #(
  parameter int         NUM_PIXELS = 784,
  parameter int         ADDR_W     = 10,
  parameter logic [7:0] THRESH     = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr_data,
  output logic              ram_we,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UNPACK,
    S_START,
    S_WAIT_DONE,
    S_TX
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          shreg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          tx_data_q;
  logic                rx_fire;
  logic                last_pixel;
  logic                unpack_done;
  logic                pixel_bit;

  assign rx_fire    = rx_valid && rx_ready;
  assign last_pixel = (addr_q == ADDR_W'(NUM_PIXELS - 1));

`ifdef SNN_LOADER_THRESH_EN
  // Grayscale mode: each byte is one pixel, written in a single cycle.
  assign unpack_done = 1'b1;
  assign pixel_bit   = (shreg_q >= THRESH);
`else
  // Packed mode: eight pixels per byte, lowest address taken from the LSB.
  logic [2:0] bitcnt_q;
  assign unpack_done = (bitcnt_q == 3'd7);
  assign pixel_bit   = shreg_q[0];

  // Bit counter for the eight writes of one packed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q <= 3'd0;
    end else if (state_q == S_LOAD && rx_fire) begin
      bitcnt_q <= 3'd0;
    end else if (state_q == S_UNPACK) begin
      bitcnt_q <= bitcnt_q + 3'd1;
    end
  end
`endif

  // State register plus the datapath registers owned by each state.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= 8'h00;
      addr_q    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD: begin
          if (rx_fire) shreg_q <= rx_data;
        end
        S_UNPACK: begin
          shreg_q <= shreg_q >> 1;
          // Hold on the final pixel; the wrap to 0 happens in START.
          if (!last_pixel) addr_q <= addr_q + 1'b1;
        end
        S_START: begin
          addr_q <= '0;
        end
        S_WAIT_DONE: begin
          if (core_done) begin
            tx_data_q <= (core_digit <= 4'd9) ? (8'h30 + {4'h0, core_digit}) : 8'h3F;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and state-decoded outputs.
  // NOTE: every output and state_d gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rx_ready   = 1'b0;
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
        if (rx_fire) state_d = S_UNPACK;
      end
      S_UNPACK: begin
        ram_we = 1'b1;
        if (unpack_done) state_d = last_pixel ? S_START : S_LOAD;
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (core_done) state_d = S_TX;
      end
      S_TX: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_wr_addr = addr_q;
  assign ram_wr_data = (state_q == S_UNPACK) ? pixel_bit : 1'b0;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader. Expected RAM writes are queued
// when each byte is handed to the DUT and popped by a monitor as writes
// appear. Also exercises the TX handshake, digit encoding, stray core_done
// and a mid-frame reset. Follows SNN_LOADER_THRESH_EN like the design.
module tb_snn_image_loader;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;
`ifdef SNN_LOADER_THRESH_EN
  localparam int BYTES     = 784;
  localparam int LAT       = 2;
  localparam int MAIN_KIND = 2;
`else
  localparam int BYTES     = 98;
  localparam int LAT       = 9;
  localparam int MAIN_KIND = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic              ram_wr_data;
  logic              ram_we;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  snn_image_loader #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .THRESH(8'h80)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_we(ram_we),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               mon_e;
  logic [ADDR_W-1:0] model_addr;
  int n_tests, n_fail;
  int start_cnt, start_cyc, hs_cyc, wr_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every RAM write is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wr_cnt++;
        check("rx_ready_in_unpack", 32'(rx_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(ram_wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(ram_wr_data), 32'(mon_e.data));
        end
      end
      if (ram_wr_addr >= ADDR_W'(NUM_PIXELS)) check("addr_range", 32'(ram_wr_addr), NUM_PIXELS - 1);
      if (core_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  function automatic logic [7:0] pick_byte(input int kind, input int j);
    logic [7:0] pat [3];
    pat[0] = 8'h7F; pat[1] = 8'h80; pat[2] = 8'hFF;
    case (kind)
      0:       return 8'hAA;
      1:       return 8'($urandom);
      default: return pat[j % 3];
    endcase
  endfunction

  function automatic void push_pixel(input logic bit_v);
    exp_q.push_back(wr_t'{addr: model_addr, data: bit_v});
    if (model_addr == ADDR_W'(NUM_PIXELS - 1)) model_addr = '0;
    else model_addr = model_addr + 1'b1;
  endfunction

  // Present one byte, wait (bounded) for the handshake and queue its pixels.
  task automatic send_byte(input logic [7:0] b);
    int i;
    rx_data  = b;
    rx_valid = 1'b1;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    if (i == 64) begin
      check("rx_ready_timeout", 32'd0, 32'd1);
    end else begin
      hs_cyc = cyc;
`ifdef SNN_LOADER_THRESH_EN
      push_pixel(b >= 8'h80);
`else
      for (int k = 0; k < 8; k++) push_pixel(b[k]);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  // rx_valid stays high across the whole frame, dropped after the last byte.
  task automatic send_frame(input int n, input int kind);
    for (int j = 0; j < n; j++) send_byte(pick_byte(kind, j));
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int base;
    int i;
    base = start_cnt;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (start_cnt != base) break;
    end
    if (i == 64) begin
      check({tag, "_start_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_start_latency"}, 32'(start_cyc - hs_cyc), LAT);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_start_count"}, 32'(start_cnt), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt), NUM_PIXELS);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_addr_after_start"}, 32'(ram_wr_addr), 32'd0);
  endtask

  // Deliver a result while the DUT waits, then hold off TX for 'hold' cycles.
  task automatic complete_tx(input string tag, input logic [3:0] d, input logic [7:0] exp, input int hold);
    check({tag, "_no_tx_in_wait"}, 32'(tx_valid), 32'd0);
    check({tag, "_busy_in_wait"}, 32'(busy), 32'd1);
    core_digit = d;
    core_done  = 1'b1;
    tx_ready   = 1'b0;
    @(negedge clk);
    check({tag, "_tx_not_same_cycle"}, 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1;
    core_done = 1'b0;
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_tx_data"}, 32'(tx_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_tx_valid_held"}, 32'(tx_valid), 32'd1);
      check({tag, "_tx_data_held"}, 32'(tx_data), 32'(exp));
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check({tag, "_tx_drop"}, 32'(tx_valid), 32'd0);
    check({tag, "_rx_ready_after_tx"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    core_done  = 1'b0;
    core_digit = 4'h0;
    tx_ready   = 1'b0;
    model_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(ram_wr_addr), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("load_rx_ready", 32'(rx_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd0);

    // Stray core_done while loading must be ignored.
    core_digit = 4'd5;
    core_done  = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(posedge clk);
    #1;
    check("stray_done_tx_valid", 32'(tx_valid), 32'd0);
    check("stray_done_rx_ready", 32'(rx_ready), 32'd1);
    check("stray_done_addr", 32'(ram_wr_addr), 32'd0);

    // Frame 1: main pattern, digit 7.
    start_cnt = 0; wr_cnt = 0;
    send_frame(BYTES, MAIN_KIND);
    wait_start("f1");
    complete_tx("d7", 4'd7, 8'h37, 5);

    // Frame 2: random bytes, out-of-range digit.
    start_cnt = 0; wr_cnt = 0;
    send_frame(BYTES, 1);
    wait_start("f2");
    complete_tx("dC", 4'hC, 8'h3F, 1);

    // Partial frame abandoned by reset mid-unpack.
    start_cnt = 0;
    send_frame(40, 1);
    repeat (3) @(posedge clk);
    #1;
    check("partial_no_start", 32'(start_cnt), 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    model_addr = '0;
    @(posedge clk);
    #1;
    check("mid_rst_addr", 32'(ram_wr_addr), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_cnt = 0; wr_cnt = 0;
    send_frame(BYTES, MAIN_KIND);
    wait_start("f3");
    complete_tx("d9", 4'd9, 8'h39, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
